ag32gbd_frame_scanner: RTL and testbench

Sequences `ag32gbd_sampler` across one full 128×FRAME_H camera frame in raster order. For each pixel it runs the sampler's start/done handshake and shifts the 2-bit result into bitplane shift registers. After every 8-pixel run it writes two bytes to the frame buffer BRAM in Game Boy 2bpp tile layout. It sits between the host/frame control logic and the sampler, and is the sampler's only driver.

---
 rtl/ag32gbd_frame_scanner.sv | 164 ++++++++++++++++
 tb/tb_ag32gbd_frame_scanner.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ag32gbd_frame_scanner.sv
// Raster scan of one camera frame through the sampler handshake,
// packing pixels into Game Boy 2bpp tile bytes for the frame buffer.
module ag32gbd_frame_scanner #(
  parameter int FRAME_H        = 112,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        sys_clock,
  input  logic        sys_resetn,
  input  logic        FrameStart,
  input  logic        FrameAbort,
  output logic        FrameBusy,
  output logic        FrameDone,
  output logic        SampleTimeout,
  output logic        SampleStart,
  output logic [6:0]  PixelX,
  output logic [6:0]  PixelY,
  input  logic        SampleDone,
  input  logic [1:0]  SampledValue,
  output logic        FbWrEn,
  output logic [11:0] FbWrAddr,
  output logic [7:0]  FbWrData
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_WR_LO   = 3'd3;
  localparam logic [2:0] S_WR_HI   = 3'd4;
  localparam logic [2:0] S_ADVANCE = 3'd5;
  localparam logic [2:0] S_DRAIN   = 3'd6;

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0] Y_LAST = 7'(FRAME_H - 1);

  logic [2:0]    state_q, state_d;
  logic [6:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [7:0]    p0_q, p0_d;
  logic [7:0]    p1_q, p1_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tout_q, tout_d;
  logic          first_q, first_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    tcnt_d  = tcnt_q;
    tout_d  = tout_q;
    first_d = first_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (FrameStart) begin
          tout_d  = 1'b0;
          x_d     = '0;
          y_d     = '0;
          tcnt_d  = '0;
          first_d = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_START: begin
        tcnt_d = tcnt_q + TW'(1);
        if (SampleDone) begin
          p0_d    = {p0_q[6:0], SampledValue[0]};
          p1_d    = {p1_q[6:0], SampledValue[1]};
          state_d = S_RELEASE;
        end else if (tcnt_q == T_LAST) begin
          // a dead sampler reads as the lightest shade
          p0_d    = {p0_q[6:0], 1'b0};
          p1_d    = {p1_q[6:0], 1'b0};
          tout_d  = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!SampleDone) begin
          if (first_q) begin
            first_d = 1'b0;
            state_d = S_START;
          end else if (&x_q[2:0]) begin
            state_d = S_WR_LO;
          end else begin
            state_d = S_ADVANCE;
          end
        end
      end
      S_WR_LO: state_d = S_WR_HI;
      S_WR_HI: state_d = S_ADVANCE;
      S_ADVANCE: begin
        tcnt_d = '0;
        if (x_q == 7'd127 && y_q == Y_LAST) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (x_q == 7'd127) begin
          x_d     = '0;
          y_d     = y_q + 7'd1;
          state_d = S_START;
        end else begin
          x_d     = x_q + 7'd1;
          state_d = S_START;
        end
      end
      S_DRAIN: begin
        if (!SampleDone) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // abort overrides every transition and discards the pending update
    if (FrameAbort && state_q != S_IDLE) begin
      state_d = S_DRAIN;
      x_d     = x_q;
      y_d     = y_q;
      p0_d    = p0_q;
      p1_d    = p1_q;
      tout_d  = tout_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      tcnt_q  <= '0;
      tout_q  <= 1'b0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      tcnt_q  <= tcnt_d;
      tout_q  <= tout_d;
      first_q <= first_d;
      done_q  <= done_d;
    end
  end

  logic wr_lo, wr_hi;

  assign wr_lo         = (state_q == S_WR_LO);
  assign wr_hi         = (state_q == S_WR_HI);
  assign FrameBusy     = (state_q != S_IDLE);
  assign FrameDone     = done_q;
  assign SampleTimeout = tout_q;
  assign SampleStart   = (state_q == S_START);
  assign PixelX        = x_q;
  assign PixelY        = y_q;
  assign FbWrEn        = wr_lo | wr_hi;
  assign FbWrAddr      = FbWrEn ? {y_q[6:3], x_q[6:3], y_q[2:0], wr_hi} : '0;
  assign FbWrData      = wr_hi ? p1_q : (wr_lo ? p0_q : '0);

endmodule

// File: tb/tb_ag32gbd_frame_scanner.sv
// Bench for ag32gbd_frame_scanner: sampler stand-in, frame buffer
// capture and an image-to-tile reference for every written byte.
module tb_ag32gbd_frame_scanner;

  localparam int FH = 16;
  localparam int TO = 16;
  localparam int NBYTES = 2 * 16 * FH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        FrameStart = 1'b0;
  logic        FrameAbort = 1'b0;
  logic        FrameBusy;
  logic        FrameDone;
  logic        SampleTimeout;
  logic        SampleStart;
  logic [6:0]  PixelX;
  logic [6:0]  PixelY;
  logic        SampleDone;
  logic [1:0]  SampledValue;
  logic        FbWrEn;
  logic [11:0] FbWrAddr;
  logic [7:0]  FbWrData;

  ag32gbd_frame_scanner #(
    .FRAME_H(FH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clock(clk),
    .sys_resetn(rst_n),
    .FrameStart(FrameStart),
    .FrameAbort(FrameAbort),
    .FrameBusy(FrameBusy),
    .FrameDone(FrameDone),
    .SampleTimeout(SampleTimeout),
    .SampleStart(SampleStart),
    .PixelX(PixelX),
    .PixelY(PixelY),
    .SampleDone(SampleDone),
    .SampledValue(SampledValue),
    .FbWrEn(FbWrEn),
    .FbWrAddr(FbWrAddr),
    .FbWrData(FbWrData)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int img [128][128];
  bit hang_en = 1'b0;
  int lat_max = 1;
  int hold_min = 1;
  int hold_max = 2;

  logic [7:0] fb [4096];
  int wc [4096];
  int wtotal, pair_err, done_cnt, max_addr;
  bit mon_en = 1'b1;
  bit prev_lo;
  logic [11:0] prev_addr;

  typedef struct {
    logic st;
    logic ab;
    logic exp_busy;
    logic exp_sstart;
  } vec_t;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int pix_exp(int x, int y);
    if (hang_en && x == 0 && y == 0) return 0;
    return img[y][x];
  endfunction

  // byte a = tile (a/16), tile row (a/2)%8, plane a%2; leftmost pixel in bit 7
  function automatic logic [7:0] exp_byte(int a);
    int tile, tx, ty, row, pl, v;
    logic [7:0] b;
    tile = a / 16;
    ty = tile / 16;
    tx = tile % 16;
    row = (a / 2) % 8;
    pl = a % 2;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      v = pix_exp(tx * 8 + k, ty * 8 + row);
      b[7-k] = v[pl];
    end
    return b;
  endfunction

  task automatic clear_sb();
    for (int i = 0; i < 4096; i++) begin
      wc[i] = 0;
      fb[i] = '0;
    end
    wtotal = 0;
    pair_err = 0;
    done_cnt = 0;
    max_addr = -1;
    prev_lo = 1'b0;
    prev_addr = '0;
  endtask

  // sampler stand-in: answers each SampleStart rise after a short delay
  initial begin : sampler
    int ph, cnt;
    ph = 0;
    cnt = 0;
    SampleDone = 1'b0;
    SampledValue = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        SampleDone = 1'b0;
        ph = 0;
      end else begin
        case (ph)
          0: if (SampleStart && !(hang_en && PixelX == 0 && PixelY == 0)) begin
            ph = 1;
            cnt = int'($urandom_range(lat_max, 0));
          end
          1: if (cnt == 0) begin
            SampleDone = 1'b1;
            SampledValue = 2'(img[PixelY][PixelX]);
            ph = 2;
            cnt = int'($urandom_range(hold_max, hold_min));
          end else cnt--;
          2: if (cnt == 0) begin
            SampleDone = 1'b0;
            ph = 3;
          end else cnt--;
          default: if (!SampleStart) ph = 0;
        endcase
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (FrameDone) done_cnt++;
        if (FbWrEn) begin
          wtotal++;
          fb[FbWrAddr] = FbWrData;
          wc[FbWrAddr]++;
          if (int'(FbWrAddr) > max_addr) max_addr = int'(FbWrAddr);
        end
        if (prev_lo && !(FbWrEn && FbWrAddr == prev_addr + 12'd1)) pair_err++;
        if (FbWrEn && FbWrAddr[0] && !prev_lo) pair_err++;
        prev_lo = FbWrEn && !FbWrAddr[0];
        prev_addr = FbWrAddr;
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic start_frame();
    FrameStart = 1'b1;
    tick();
    FrameStart = 1'b0;
  endtask

  task automatic run_to_done(string tag);
    int n;
    n = 0;
    while (!FrameDone && n < 25000) begin
      tick();
      n++;
    end
    if (!FrameDone) chk({tag, "_done_timeout"}, 0, 1);
    else chk({tag, "_busy_at_done"}, int'(FrameBusy), 0);
    repeat (3) tick();
  endtask

  task automatic check_frame(string tag);
    int bad, dup;
    bad = 0;
    dup = 0;
    for (int a = 0; a < NBYTES; a++) begin
      if (wc[a] != 1) dup++;
      if (fb[a] !== exp_byte(a)) bad++;
    end
    chk({tag, "_writes"}, wtotal, NBYTES);
    chk({tag, "_bad_bytes"}, bad, 0);
    chk({tag, "_addr_not_once"}, dup, 0);
    chk({tag, "_last_addr"}, max_addr, NBYTES - 1);
    chk({tag, "_pairing"}, pair_err, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, int'(FrameBusy), 0);
    chk({tag, "_done"}, int'(FrameDone), 0);
    chk({tag, "_tout"}, int'(SampleTimeout), 0);
    chk({tag, "_sstart"}, int'(SampleStart), 0);
    chk({tag, "_x"}, int'(PixelX), 0);
    chk({tag, "_y"}, int'(PixelY), 0);
    chk({tag, "_wren"}, int'(FbWrEn), 0);
    chk({tag, "_addr"}, int'(FbWrAddr), 0);
    chk({tag, "_data"}, int'(FbWrData), 0);
  endtask

  initial begin : main
    vec_t vt [4];
    int n, viol, nz;
    vt[0] = '{st: 1'b0, ab: 1'b0, exp_busy: 1'b0, exp_sstart: 1'b0};
    vt[1] = '{st: 1'b0, ab: 1'b1, exp_busy: 1'b0, exp_sstart: 1'b0};
    vt[2] = '{st: 1'b1, ab: 1'b0, exp_busy: 1'b1, exp_sstart: 1'b1};
    vt[3] = '{st: 1'b1, ab: 1'b1, exp_busy: 1'b1, exp_sstart: 1'b1};
    for (int y = 0; y < 128; y++)
      for (int x = 0; x < 128; x++) img[y][x] = x % 4;
    clear_sb();

    repeat (2) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      clear_sb();
      FrameStart = vt[i].st;
      FrameAbort = vt[i].ab;
      tick();
      FrameStart = 1'b0;
      FrameAbort = 1'b0;
      chk($sformatf("vec%0d_busy", i), int'(FrameBusy), int'(vt[i].exp_busy));
      tick();
      chk($sformatf("vec%0d_sstart", i), int'(SampleStart), int'(vt[i].exp_sstart));
      chk($sformatf("vec%0d_x", i), int'(PixelX), 0);
      FrameAbort = 1'b1;
      tick();
      FrameAbort = 1'b0;
      n = 0;
      while (FrameBusy && n < 100) begin
        tick();
        n++;
      end
      repeat (10) tick();
      chk($sformatf("vec%0d_idle", i), int'(FrameBusy), 0);
      chk($sformatf("vec%0d_writes", i), wtotal, 0);
      chk($sformatf("vec%0d_donecnt", i), done_cnt, 0);
    end

    // X-column pattern frame
    clear_sb();
    start_frame();
    run_to_done("xpat");
    check_frame("xpat");
    chk("xpat_plane0", int'(fb[0]), 'h55);
    chk("xpat_plane1", int'(fb[1]), 'h33);

    // random image, first pixel never answered
    for (int y = 0; y < 128; y++)
      for (int x = 0; x < 128; x++) img[y][x] = int'($urandom_range(3, 0));
    hang_en = 1'b1;
    clear_sb();
    start_frame();
    n = 0;
    while (!SampleStart && n < 20) begin
      tick();
      n++;
    end
    n = 0;
    while (SampleStart && n < 100) begin
      n++;
      tick();
    end
    chk("timeout_len", n, TO);
    chk("timeout_flag", int'(SampleTimeout), 1);
    n = 0;
    while (PixelY != 7'd2 && n < 10000) begin
      tick();
      n++;
    end
    start_frame();
    chk("ignore_y_kept", int'(PixelY >= 7'd2), 1);
    chk("ignore_busy", int'(FrameBusy), 1);
    chk("ignore_tout", int'(SampleTimeout), 1);
    run_to_done("rand");
    check_frame("rand");
    chk("tout_b0_bit7", int'(fb[0][7]), 0);
    chk("tout_b1_bit7", int'(fb[1][7]), 0);
    chk("tout_sticky", int'(SampleTimeout), 1);
    hang_en = 1'b0;

    // single dark pixel at (8,9)
    for (int y = 0; y < 128; y++)
      for (int x = 0; x < 128; x++) img[y][x] = 0;
    img[9][8] = 3;
    clear_sb();
    start_frame();
    chk("restart_tout", int'(SampleTimeout), 0);
    chk("restart_x", int'(PixelX), 0);
    chk("restart_y", int'(PixelY), 0);
    chk("restart_busy", int'(FrameBusy), 1);
    run_to_done("addr");
    check_frame("addr");
    chk("addr_lo", int'(fb[12'h112]), 'h80);
    chk("addr_hi", int'(fb[12'h113]), 'h80);
    nz = 0;
    for (int a = 0; a < NBYTES; a++) if (fb[a] != 8'h00) nz++;
    chk("addr_nonzero", nz, 2);
    chk("addr_tout", int'(SampleTimeout), 0);

    // abort while the sampler holds done
    for (int y = 0; y < 128; y++)
      for (int x = 0; x < 128; x++) img[y][x] = x % 4;
    hold_min = 4;
    hold_max = 4;
    clear_sb();
    start_frame();
    n = 0;
    while (!(PixelX == 7'd3 && PixelY == 7'd0 && SampleDone) && n < 500) begin
      tick();
      n++;
    end
    chk("abort_reached", int'(SampleDone), 1);
    FrameAbort = 1'b1;
    tick();
    FrameAbort = 1'b0;
    chk("abort_sstart", int'(SampleStart), 0);
    chk("abort_drain_busy", int'(FrameBusy), 1);
    viol = 0;
    n = 0;
    while (FrameBusy && n < 200) begin
      tick();
      n++;
      if (!FrameBusy && SampleDone) viol++;
    end
    chk("abort_drain_order", viol, 0);
    repeat (5) tick();
    chk("abort_idle", int'(FrameBusy), 0);
    chk("abort_writes", wtotal, 0);
    chk("abort_done", done_cnt, 0);
    hold_min = 1;
    hold_max = 2;

    // reset in the middle of a low-plane write
    clear_sb();
    start_frame();
    n = 0;
    while (!FbWrEn && n < 1000) begin
      tick();
      n++;
    end
    chk("rst_in_wrlo", int'(FbWrEn && !FbWrAddr[0]), 1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    repeat (3) tick();
    rst_n = 1'b1;
    clear_sb();
    mon_en = 1'b1;
    repeat (30) tick();
    chk("postrst_busy", int'(FrameBusy), 0);
    chk("postrst_writes", wtotal, 0);
    chk("postrst_done", done_cnt, 0);
    chk("postrst_sstart", int'(SampleStart), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
